bsr_mem_responder: RTL and testbench

- Memory-side responder for the 128-bit line bus that the CPU core's conjoined memory tile initiates on.
- Backs the bus with an internal line array and adds a configurable access latency to model external RAM.
- Sits at the far end of the core's memAddr/memOpm/memInData/memOutData/memOK interface, in simulation tops and FPGA builds.

---
 rtl/bsr_mem_if.sv | 25 ++
 rtl/bsr_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_bsr_mem_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsr_mem_if.sv
// Line-bus bundle between the CPU memory tile (master) and a memory responder (slave).
// Carries the memAddr/memOpm/memInData/memOutData/memOK handshake of the 128-bit line bus.
interface bsr_mem_if;
    logic [127:0] memInData;
    logic [127:0] memOutData;
    logic [31:0]  memAddr;
    logic [4:0]   memOpm;
    logic [1:0]   memOK;

    modport master (
        output memInData,
        output memAddr,
        output memOpm,
        input  memOutData,
        input  memOK
    );

    modport slave (
        input  memInData,
        input  memAddr,
        input  memOpm,
        output memOutData,
        output memOK
    );
endinterface

// File: rtl/bsr_mem_responder.sv
// Memory-side responder for the 128-bit line bus: an internal line array behind a
// configurable number of WAIT cycles, one access in flight at a time.
module bsr_mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 3
) (
    input  logic      clock,
    input  logic      reset,
    bsr_mem_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OK_READY = 2'd0;
    localparam logic [1:0] OK_OK    = 2'd1;
    localparam logic [1:0] OK_HOLD  = 2'd2;
    localparam logic [1:0] OK_FAULT = 2'd3;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int HI_W  = 28 - ADDR_BITS;
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_op;
    logic [ADDR_BITS-1:0] r_idx;
    logic [127:0]         r_data;
    logic                 r_fault;
    logic [127:0]         r_out;
    logic [127:0]         r_mem [DEPTH];

    logic                 w_req;
    logic                 w_bad;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_do_acc;
    logic [1:0]           w_acc_op;
    logic [ADDR_BITS-1:0] w_acc_idx;
    logic [127:0]         w_acc_data;
    logic [1:0]           w_ok;
    logic                 w_unused_addr;

    assign w_req         = (bus.memOpm[4:3] != OP_NONE);
    assign w_idx         = bus.memAddr[ADDR_BITS+3:4];
    assign w_bad         = (bus.memOpm[4:3] == OP_RSVD) || (bus.memOpm[2:0] != 3'b111) ||
                           (bus.memAddr[31:ADDR_BITS+4] != {HI_W{1'b0}});
    assign w_unused_addr = ^bus.memAddr[3:0];

    // Select the access source: live bus for a zero-latency hit, latched request otherwise.
    always_comb begin
        w_do_acc   = 1'b0;
        w_acc_op   = r_op;
        w_acc_idx  = r_idx;
        w_acc_data = r_data;
        case (r_state)
            ST_IDLE: begin
                w_acc_op   = bus.memOpm[4:3];
                w_acc_idx  = w_idx;
                w_acc_data = bus.memInData;
                if (LATENCY == 0) begin
                    w_do_acc = w_req && !w_bad;
                end else begin
                    w_do_acc = 1'b0;
                end
            end
            ST_WAIT: begin
                if (w_req && (r_cnt == {CNT_W{1'b0}})) begin
                    w_do_acc = 1'b1;
                end else begin
                    w_do_acc = 1'b0;
                end
            end
            default: w_do_acc = 1'b0;
        endcase
    end

    // Bus status decode from state and the live request.
    always_comb begin
        w_ok = OK_READY;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_ok = OK_HOLD;
                end else begin
                    w_ok = OK_READY;
                end
            end
            ST_WAIT: w_ok = OK_HOLD;
            ST_DONE: begin
                if (r_fault) begin
                    w_ok = OK_FAULT;
                end else begin
                    w_ok = OK_OK;
                end
            end
            default: w_ok = OK_READY;
        endcase
    end

    assign bus.memOK      = w_ok;
    assign bus.memOutData = r_out;

    // Request sequencing, latching and load/echo data register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_op    <= OP_NONE;
            r_idx   <= {ADDR_BITS{1'b0}};
            r_data  <= 128'd0;
            r_fault <= 1'b0;
            r_out   <= 128'd0;
        end else begin
            if (w_do_acc) begin
                r_out <= (w_acc_op == OP_LOAD) ? r_mem[w_acc_idx] : w_acc_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_op   <= bus.memOpm[4:3];
                        r_idx  <= w_idx;
                        r_data <= bus.memInData;
                        if (w_bad) begin
                            r_fault <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (LATENCY == 0) begin
                            r_fault <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_fault <= 1'b0;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Dropping the request mid-wait abandons the access entirely.
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Line array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && w_do_acc && (w_acc_op == OP_STORE)) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

endmodule

// File: tb/tb_bsr_mem_responder.sv
// Randomised self-checking bench: a LATENCY=3 and a LATENCY=0 responder checked against
// a transaction-level model of the line store and the bus status timeline.
module tb_bsr_mem_responder;

    localparam logic [1:0] K_READY = 2'd0;
    localparam logic [1:0] K_OK    = 2'd1;
    localparam logic [1:0] K_HOLD  = 2'd2;
    localparam logic [1:0] K_FAULT = 2'd3;

    logic         clock = 1'b0;
    logic         reset;
    bit           sel;
    logic [4:0]   drv_opm;
    logic [31:0]  drv_addr;
    logic [127:0] drv_data;
    logic [1:0]   obs_ok;
    logic [127:0] obs_out;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] mdl [int];
    logic [127:0] exp_out [2];

    always #5 clock = ~clock;

    bsr_mem_if if_a ();
    bsr_mem_if if_b ();

    assign if_a.memOpm    = sel ? 5'd0 : drv_opm;
    assign if_b.memOpm    = sel ? drv_opm : 5'd0;
    assign if_a.memAddr   = drv_addr;
    assign if_b.memAddr   = drv_addr;
    assign if_a.memInData = drv_data;
    assign if_b.memInData = drv_data;
    assign obs_ok  = sel ? if_b.memOK : if_a.memOK;
    assign obs_out = sel ? if_b.memOutData : if_a.memOutData;

    bsr_mem_responder #(.ADDR_BITS(12), .LATENCY(3)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a)
    );

    bsr_mem_responder #(.ADDR_BITS(12), .LATENCY(0)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d: got %h expected %h", tag, sel, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic [4:0] opm, input logic [31:0] addr, input logic [127:0] data);
        @(negedge clock);
        drv_opm  = opm;
        drv_addr = addr;
        drv_data = data;
        #1;
    endtask

    // One complete bus transaction from request to READY, with the status expected each cycle.
    task automatic xfer(input bit s, input logic [1:0] op, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [127:0] data,
                        input int abort_k, input int hold);
        int  lat;
        bit  flt;
        int  key;
        logic [4:0] opm;
        lat = s ? 0 : 3;
        flt = (op == 2'b11) || (sz != 3'b111) || (addr[31:16] != 16'd0);
        key = (s ? 4096 : 0) + int'(addr[15:4]);
        opm = {op, sz};
        sel = s;
        drive(opm, addr, data);
        check_eq("req_hold", 128'(obs_ok), 128'(K_HOLD));
        if (flt) begin
            for (int c = 0; c <= hold; c++) begin
                drive(opm, $urandom, rnd128());
                check_eq("fault_ok", 128'(obs_ok), 128'(K_FAULT));
                check_eq("fault_out", obs_out, exp_out[s]);
            end
            drive(5'd0, $urandom, rnd128());
            check_eq("fault_release", 128'(obs_ok), 128'(K_FAULT));
        end else if (abort_k > 0) begin
            for (int c = 1; c < abort_k; c++) begin
                drive(opm, $urandom, rnd128());
                check_eq("wait_hold", 128'(obs_ok), 128'(K_HOLD));
            end
            drive(5'd0, $urandom, rnd128());
            check_eq("abort_hold", 128'(obs_ok), 128'(K_HOLD));
        end else begin
            for (int c = 1; c <= lat; c++) begin
                drive(opm, $urandom, rnd128());
                check_eq("wait_hold", 128'(obs_ok), 128'(K_HOLD));
            end
            if (op == 2'b10) begin
                mdl[key] = data;
                exp_out[s] = data;
            end else begin
                exp_out[s] = mdl[key];
            end
            for (int c = 0; c <= hold; c++) begin
                drive(opm, $urandom, rnd128());
                check_eq("done_ok", 128'(obs_ok), 128'(K_OK));
                check_eq("done_out", obs_out, exp_out[s]);
            end
            drive(5'd0, $urandom, rnd128());
            check_eq("done_release", 128'(obs_ok), 128'(K_OK));
        end
        drive(5'd0, $urandom, rnd128());
        check_eq("ready", 128'(obs_ok), 128'(K_READY));
        check_eq("ready_out", obs_out, exp_out[s]);
    endtask

    initial begin
        logic [127:0] pat;
        logic [31:0]  a;
        int           line;
        int           kind;
        bit           s;
        reset    = 1'b1;
        sel      = 1'b0;
        drv_opm  = 5'd0;
        drv_addr = 32'd0;
        drv_data = 128'd0;
        exp_out[0] = 128'd0;
        exp_out[1] = 128'd0;
        #12;
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            check_eq("rst_ok", 128'(obs_ok), 128'(K_READY));
            check_eq("rst_out", obs_out, 128'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Store/load round trip and low-address-bit aliasing.
        pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
        xfer(1'b0, 2'b10, 3'b111, 32'h0000_0120, pat, 0, 0);
        xfer(1'b0, 2'b01, 3'b111, 32'h0000_0120, rnd128(), 0, 2);
        xfer(1'b0, 2'b10, 3'b111, 32'h0000_012C, rnd128(), 0, 0);
        xfer(1'b0, 2'b01, 3'b111, 32'h0000_0120, rnd128(), 0, 0);

        // Faults: out of range, reserved op, bad size, out-of-range store.
        xfer(1'b0, 2'b01, 3'b111, 32'h0001_0000, rnd128(), 0, 3);
        xfer(1'b0, 2'b11, 3'b111, 32'h0000_0120, rnd128(), 0, 1);
        xfer(1'b0, 2'b01, 3'b011, 32'h0000_0120, rnd128(), 0, 1);
        xfer(1'b0, 2'b10, 3'b111, 32'h0001_0120, rnd128(), 0, 0);
        xfer(1'b0, 2'b10, 3'b110, 32'h0000_0120, rnd128(), 0, 0);
        xfer(1'b0, 2'b01, 3'b111, 32'h0000_0120, rnd128(), 0, 0);

        // Abort after one HOLD cycle leaves the old line intact.
        xfer(1'b0, 2'b10, 3'b111, 32'h0000_0050, {32{4'hA}}, 0, 0);
        xfer(1'b0, 2'b10, 3'b111, 32'h0000_0050, {32{4'h5}}, 1, 0);
        xfer(1'b0, 2'b01, 3'b111, 32'h0000_0050, rnd128(), 0, 0);

        // Reset in the middle of a store's wait period.
        xfer(1'b0, 2'b10, 3'b111, 32'h0000_0070, {32{4'h1}}, 0, 0);
        sel = 1'b0;
        drive(5'b10111, 32'h0000_0070, {32{4'h2}});
        drive(5'b10111, 32'h0000_0070, {32{4'h2}});
        @(negedge clock);
        drv_opm = 5'd0;
        reset   = 1'b1;
        #1;
        exp_out[0] = 128'd0;
        exp_out[1] = 128'd0;
        check_eq("rst_wait_ok", 128'(obs_ok), 128'(K_READY));
        check_eq("rst_wait_out", obs_out, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        xfer(1'b0, 2'b01, 3'b111, 32'h0000_0070, rnd128(), 0, 0);

        // Zero-latency responder: stable DONE hold, back-to-back loads, fault.
        xfer(1'b1, 2'b10, 3'b111, 32'h0000_0030, rnd128(), 0, 0);
        xfer(1'b1, 2'b01, 3'b111, 32'h0000_0030, rnd128(), 0, 5);
        xfer(1'b1, 2'b10, 3'b111, 32'h0000_0FF0, rnd128(), 0, 0);
        xfer(1'b1, 2'b01, 3'b111, 32'h0000_0030, rnd128(), 0, 0);
        xfer(1'b1, 2'b01, 3'b111, 32'h0000_0FFF, rnd128(), 0, 0);
        xfer(1'b1, 2'b01, 3'b111, 32'h8000_0030, rnd128(), 0, 2);

        // Randomised mix of stores, loads, faults and aborts on both responders.
        for (int it = 0; it < 80; it++) begin
            s    = it[0];
            line = int'($urandom_range(0, 15));
            a    = {16'h0000, 12'(line), 4'($urandom)};
            kind = int'($urandom_range(0, 9));
            if (kind < 4) begin
                xfer(s, 2'b10, 3'b111, a, rnd128(), 0, int'($urandom_range(0, 3)));
            end else if (kind < 7) begin
                if (mdl.exists((s ? 4096 : 0) + line)) begin
                    xfer(s, 2'b01, 3'b111, a, rnd128(), 0, int'($urandom_range(0, 3)));
                end else begin
                    xfer(s, 2'b10, 3'b111, a, rnd128(), 0, 0);
                end
            end else if (kind == 7) begin
                xfer(s, 2'b10, 3'b111, a | 32'h0100_0000, rnd128(), 0, int'($urandom_range(0, 2)));
            end else if (kind == 8) begin
                xfer(s, 2'b10, 3'($urandom_range(0, 6)), a, rnd128(), 0, 0);
            end else if (!s) begin
                xfer(s, 2'b10, 3'b111, a, rnd128(), int'($urandom_range(1, 3)), 0);
            end else begin
                xfer(s, 2'b11, 3'b111, a, rnd128(), 0, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
